// File: rtl/reg_file_sb_if.sv
// Decode/write-back bundle for reg_file_sb: read and reserve requests, write-back, read results.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid_opcode;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              out_valid;
  logic              stall;

  modport master (
    output valid_opcode, addr1, addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
    input  out1, out2, out_valid, stall
  );

  modport slave (
    input  valid_opcode, addr1, addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
    output out1, out2, out_valid, stall
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a pending-result scoreboard, optional R0=0
// and optional write-to-read forwarding.
module reg_file_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic              hit1, hit2, haz1, haz2;
  logic              accept, wr_ok, rsv_ok;
  logic [DATA_W-1:0] eff1, eff2;

  // A same-cycle write to a read address both forwards its data and resolves the hazard.
  assign hit1 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.addr1);
  assign hit2 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.addr2);
  assign haz1 = pending[bus.addr1] && !hit1;
  assign haz2 = pending[bus.addr2] && !hit2;

  always_comb begin
    eff1 = mem[bus.addr1];
    if (hit1) eff1 = bus.wr_data;
    if ((R0_ZERO != 0) && (bus.addr1 == '0)) eff1 = '0;
  end

  always_comb begin
    eff2 = mem[bus.addr2];
    if (hit2) eff2 = bus.wr_data;
    if ((R0_ZERO != 0) && (bus.addr2 == '0)) eff2 = '0;
  end

  assign bus.stall = rst_n && bus.valid_opcode && (haz1 || haz2);
  assign accept    = bus.valid_opcode && !bus.stall;
  assign wr_ok     = bus.wr_en && !((R0_ZERO != 0) && (bus.wr_addr == '0));
  assign rsv_ok    = accept && bus.rsv_en && !((R0_ZERO != 0) && (bus.rsv_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending       <= '0;
      bus.out1      <= '0;
      bus.out2      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ok ? bus.wr_addr : bus.wr_addr] <= bus.wr_data;
        pending[bus.wr_addr] <= 1'b0;
      end
      // Placed after the write so a same-edge reservation of the written register wins.
      if (rsv_ok) pending[bus.rsv_addr] <= 1'b1;
      if (accept) begin
        bus.out1      <= eff1;
        bus.out2      <= eff2;
        bus.out_valid <= 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
